// File: rtl/qspi_rom_fetch_cache_pkg.sv
// Shared types and constants for the QSPI ROM fetch cache: one-hot FSM
// encoding, data word width and tag-width derivation.
package qspi_rom_fetch_cache_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_LOOKUP  = 4'b0010,
    ST_FILL    = 4'b0100,
    ST_RELEASE = 4'b1000
  } state_e;

  // Byte address minus the 2 word-offset bits and the index bits.
  function automatic int tag_width(input int addr_width, input int index_bits);
    return addr_width - 2 - index_bits;
  endfunction

endpackage

// File: rtl/rom_cache_store.sv
// Tag/data storage for the fetch cache: synchronous read, single write port,
// no reset (line validity lives in the parent).
module rom_cache_store
  import qspi_rom_fetch_cache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_W      = 18
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [WORD_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [WORD_WIDTH-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [TAG_W-1:0]      mem_tag_q  [LINES];
  logic [WORD_WIDTH-1:0] mem_data_q [LINES];
  logic [TAG_W-1:0]      rd_tag_q;
  logic [WORD_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_tag_q[wr_index]  <= wr_tag;
      mem_data_q[wr_index] <= wr_data;
    end
    if (rd_en) begin
      rd_tag_q  <= mem_tag_q[rd_index];
      rd_data_q <= mem_data_q[rd_index];
    end
  end

  assign rd_tag  = rd_tag_q;
  assign rd_data = rd_data_q;

endmodule

// File: rtl/qspi_rom_fetch_cache.sv
// Direct-mapped, one-word-per-line read cache between the CPU fetch port and
// the QSPI ROM controller. Both sides use a 4-phase req/ack handshake.
module qspi_rom_fetch_cache
  import qspi_rom_fetch_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_req,
  output logic                  cpu_ack,
  output logic [WORD_WIDTH-1:0] cpu_data,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_req,
  input  logic                  rom_ack,
  input  logic [WORD_WIDTH-1:0] rom_data,
  output state_e                dbg_state
);

  // Handshake: a requester raises req and holds it until it sees ack; the
  // responder holds ack until req falls, then drops ack. A new req is only
  // raised once ack is low again.

  localparam int TAG_W = tag_width(ADDR_WIDTH, INDEX_BITS);
  localparam int LINES = 1 << INDEX_BITS;

  state_e                  state_q, state_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic [WORD_WIDTH-1:0]   cpu_data_q, cpu_data_d;
  logic                    rom_req_q, rom_req_d;
  logic [ADDR_WIDTH-1:0]   rom_address_q, rom_address_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [ADDR_WIDTH-3:0]   addr_q, addr_d;

  logic [INDEX_BITS-1:0]   lk_index;
  logic [TAG_W-1:0]        lk_tag;
  logic                    st_rd_en;
  logic                    st_wr_en;
  logic [TAG_W-1:0]        st_tag;
  logic [WORD_WIDTH-1:0]   st_data;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^cpu_address[1:0];
  assign lk_index         = addr_q[INDEX_BITS-1:0];
  assign lk_tag           = addr_q[ADDR_WIDTH-3:INDEX_BITS];

  rom_cache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk      (clk),
    .rd_en    (st_rd_en),
    .rd_index (cpu_address[INDEX_BITS+1:2]),
    .rd_tag   (st_tag),
    .rd_data  (st_data),
    .wr_en    (st_wr_en),
    .wr_index (lk_index),
    .wr_tag   (lk_tag),
    .wr_data  (rom_data)
  );

  always_comb begin
    state_d         = state_q;
    cpu_ack_d       = cpu_ack_q;
    cpu_data_d      = cpu_data_q;
    rom_req_d       = rom_req_q;
    rom_address_d   = rom_address_q;
    valid_d         = valid_q;
    flush_pending_d = flush_pending_q;
    addr_d          = addr_q;
    st_rd_en        = 1'b0;
    st_wr_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !cpu_ack_q) begin
          addr_d   = cpu_address[ADDR_WIDTH-1:2];
          st_rd_en = 1'b1;
          state_d  = ST_LOOKUP;
        end else if (!cpu_req) begin
          cpu_ack_d = 1'b0;
        end
      end
      ST_LOOKUP: begin
        if (valid_q[lk_index] && (st_tag == lk_tag) && !flush) begin
          cpu_data_d = st_data;
          cpu_ack_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          rom_address_d = {addr_q, 2'b00};
          rom_req_d     = 1'b1;
          state_d       = ST_FILL;
        end
      end
      ST_FILL: begin
        if (flush) flush_pending_d = 1'b1;
        if (rom_ack) begin
          st_wr_en          = 1'b1;
          valid_d[lk_index] = !(flush_pending_q || flush);
          cpu_data_d        = rom_data;
          cpu_ack_d         = 1'b1;
          rom_req_d         = 1'b0;
          state_d           = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (flush) flush_pending_d = 1'b1;
        if (!cpu_req) cpu_ack_d = 1'b0;
        if (!rom_ack) begin
          flush_pending_d = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Applied last so a flush always beats a same-cycle line fill.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q         <= ST_IDLE;
      cpu_ack_q       <= 1'b0;
      cpu_data_q      <= '0;
      rom_req_q       <= 1'b0;
      rom_address_q   <= '0;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      addr_q          <= '0;
    end else begin
      state_q         <= state_d;
      cpu_ack_q       <= cpu_ack_d;
      cpu_data_q      <= cpu_data_d;
      rom_req_q       <= rom_req_d;
      rom_address_q   <= rom_address_d;
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      addr_q          <= addr_d;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_data    = cpu_data_q;
  assign rom_req     = rom_req_q;
  assign rom_address = rom_address_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_qspi_rom_fetch_cache.sv
// Self-checking bench for qspi_rom_fetch_cache: behavioural ROM controller,
// CPU fetch driver and an expected-data queue.
module tb_qspi_rom_fetch_cache;
  import qspi_rom_fetch_cache_pkg::*;

  logic        clk;
  logic        nreset;
  logic [23:0] cpu_address;
  logic        cpu_req;
  logic        cpu_ack;
  logic [31:0] cpu_data;
  logic        flush;
  logic [23:0] rom_address;
  logic        rom_req;
  logic        rom_ack;
  logic [31:0] rom_data;
  state_e      dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          rom_reads = 0;
  int          rom_delay = 20;
  int          rom_ack_cyc = 0;
  logic [23:0] last_rom_addr = '0;
  logic [31:0] rom_gen = '0;
  logic [31:0] exp_q[$];

  logic        m_valid [16];
  logic [17:0] m_tag   [16];

  qspi_rom_fetch_cache dut (
    .clk         (clk),
    .nreset      (nreset),
    .cpu_address (cpu_address),
    .cpu_req     (cpu_req),
    .cpu_ack     (cpu_ack),
    .cpu_data    (cpu_data),
    .flush       (flush),
    .rom_address (rom_address),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [23:0] a);
    logic [23:0] wa;
    wa = {a[23:2], 2'b00};
    if (wa == 24'h000104) return 32'hDEADBEEF ^ rom_gen;
    return {8'hA5, wa} ^ rom_gen;
  endfunction

  // ---------------- ROM controller model ----------------
  initial begin
    bit aborted;
    rom_ack  = 1'b0;
    rom_data = '0;
    forever begin
      @(negedge clk);
      if (rom_req && !rom_ack) begin
        rom_reads++;
        last_rom_addr = rom_address;
        aborted = 1'b0;
        for (int i = 0; i < rom_delay; i++) begin
          @(negedge clk);
          if (!rom_req) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          rom_data    = rom_word(rom_address);
          rom_ack     = 1'b1;
          rom_ack_cyc = cyc;
          for (int i = 0; i < 50 && rom_req; i++) @(negedge clk);
          rom_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic fetch(input logic [23:0] addr, input logic [31:0] exp,
                       input bit exp_miss, input bit flush_mid);
    int          reads0;
    int          start;
    bit          got_ack;
    bit          flushed;
    logic [31:0] e;
    check("idle_rom_req", {31'd0, rom_req}, 32'd0);
    reads0 = rom_reads;
    exp_q.push_back(exp);
    cpu_address = addr;
    cpu_req     = 1'b1;
    start       = cyc;
    got_ack     = 1'b0;
    flushed     = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      flush = 1'b0;
      if (cpu_ack) begin
        got_ack = 1'b1;
        break;
      end
      if (flush_mid && rom_req && !flushed) begin
        flush   = 1'b1;
        flushed = 1'b1;
      end
    end
    check("ack_seen", {31'd0, got_ack}, 32'd1);
    e = exp_q.pop_front();
    if (got_ack) begin
      check("cpu_data", cpu_data, e);
      check("rom_reads", 32'(rom_reads - reads0), {31'd0, exp_miss});
      if (exp_miss) begin
        check("rom_address", {8'd0, last_rom_addr}, {8'd0, addr[23:2], 2'b00});
        check("ack_after_rom_ack", {31'd0, cyc > rom_ack_cyc}, 32'd1);
      end else begin
        check("hit_latency", 32'(cyc - start), 32'd2);
      end
    end
    cpu_req = 1'b0;
    for (int n = 0; n < 10 && cpu_ack; n++) @(negedge clk);
    check("ack_release", {31'd0, cpu_ack}, 32'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          saw_req;
    logic [23:0] a;
    logic [3:0]  idx;
    logic [17:0] tg;
    bit          miss;

    nreset      = 1'b0;
    cpu_address = '0;
    cpu_req     = 1'b0;
    flush       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ack",  {31'd0, cpu_ack}, 32'd0);
    check("rst_cpu_data", cpu_data, 32'd0);
    check("rst_rom_req",  {31'd0, rom_req}, 32'd0);
    check("rst_rom_addr", {8'd0, rom_address}, 32'd0);
    check("rst_state",    32'(dbg_state), 32'(4'b0001));
    nreset = 1'b1;
    @(negedge clk);

    // cold miss, then hit on the same word with different byte offset
    rom_delay = 20;
    fetch(24'h000104, 32'hDEADBEEF, 1'b1, 1'b0);
    fetch(24'h000106, 32'hDEADBEEF, 1'b0, 1'b0);

    // conflict on index 1
    rom_delay = 5;
    fetch(24'h000144, rom_word(24'h000144), 1'b1, 1'b0);
    fetch(24'h000104, 32'hDEADBEEF, 1'b1, 1'b0);
    fetch(24'h000104, 32'hDEADBEEF, 1'b0, 1'b0);

    // flush forces a re-read; ROM content changes to prove fresh data
    pulse_flush();
    rom_gen = 32'h1;
    fetch(24'h000104, 32'hDEADBEEE, 1'b1, 1'b0);
    fetch(24'h000104, 32'hDEADBEEE, 1'b0, 1'b0);

    // flush during fill: data still returned, line left invalid
    fetch(24'h000148, rom_word(24'h000148), 1'b1, 1'b1);
    fetch(24'h000148, rom_word(24'h000148), 1'b1, 1'b0);
    fetch(24'h000148, rom_word(24'h000148), 1'b0, 1'b0);

    // async reset in the middle of a fill
    fetch(24'h0001C0, rom_word(24'h0001C0), 1'b1, 1'b0);
    fetch(24'h0001C0, rom_word(24'h0001C0), 1'b0, 1'b0);
    rom_delay   = 20;
    cpu_address = 24'h000200;
    cpu_req     = 1'b1;
    saw_req     = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rom_req) begin
        saw_req = 1'b1;
        break;
      end
    end
    check("midfill_rom_req", {31'd0, saw_req}, 32'd1);
    repeat (5) @(negedge clk);
    nreset = 1'b0;
    #1;
    check("midrst_rom_req", {31'd0, rom_req}, 32'd0);
    check("midrst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("midrst_state",   32'(dbg_state), 32'(4'b0001));
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    rom_delay = 4;
    fetch(24'h000200, rom_word(24'h000200), 1'b1, 1'b0);
    fetch(24'h0001C0, rom_word(24'h0001C0), 1'b1, 1'b0);

    // random traffic against a reference tag/valid model
    pulse_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      a         = (24'($urandom_range(0, 63)) << 2) | 24'($urandom_range(0, 3));
      idx       = a[5:2];
      tg        = a[23:6];
      miss      = !(m_valid[idx] && (m_tag[idx] == tg));
      rom_delay = $urandom_range(1, 6);
      fetch(a, rom_word(a), miss, 1'b0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
